// File: rtl/stim_mode_sequencer.sv
// Mode-sweep sequencer for BER screening: walks {MAIN_MODE, SUB_MODE}, pulses POR,
// settles, counts ERR over a measurement window and hands each result to a logger.
module stim_mode_sequencer #(
  parameter int MODE_FIRST = 9,
  parameter int MODE_LAST  = 31,
  parameter int SUB_LAST   = 63,
  parameter int POR_CYC    = 16,
  parameter int SETTLE_CYC = 256,
  parameter int MEAS_CYC   = 65536,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic             ERR,
  input  logic             RES_READY,
  output logic [7:0]       MAIN_MODE,
  output logic [7:0]       SUB_MODE,
  output logic             POR,
  output logic             MEAS_EN,
  output logic             RES_VALID,
  output logic [15:0]      RES_MODE,
  output logic [CNT_W-1:0] RES_ERRS,
  output logic             BUSY,
  output logic             DONE
);

  localparam int MAX_PS  = (POR_CYC > SETTLE_CYC) ? POR_CYC : SETTLE_CYC;
  localparam int MAX_CYC = (MAX_PS > MEAS_CYC) ? MAX_PS : MEAS_CYC;
  localparam int CYC_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CYC_W-1:0] POR_LOAD    = CYC_W'(POR_CYC - 1);
  localparam logic [CYC_W-1:0] SETTLE_LOAD = CYC_W'(SETTLE_CYC - 1);
  localparam logic [CYC_W-1:0] MEAS_LOAD   = CYC_W'(MEAS_CYC - 1);
  localparam logic [7:0]       FIRST8      = 8'(MODE_FIRST);
  localparam logic [7:0]       LAST8       = 8'(MODE_LAST);
  localparam logic [7:0]       SUB8        = 8'(SUB_LAST);

  typedef enum logic [2:0] {
    S_IDLE, S_POR, S_SETTLE, S_MEAS, S_REPORT, S_DONE
  } state_t;

  state_t            state, state_n;
  logic [CYC_W-1:0]  cnt, cnt_n;
  logic [CNT_W-1:0]  err_cnt, err_cnt_n, res_errs_n;
  logic [7:0]        main_n, sub_n;
  logic [15:0]       res_mode_n;
  logic              por_n, meas_en_n, res_valid_n, busy_n, done_n;

  // NOTE: every state and output register is updated with <= so all of them
  // sample the same pre-edge values; the comb block below uses = only.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      err_cnt   <= '0;
      MAIN_MODE <= FIRST8;
      SUB_MODE  <= 8'd0;
      POR       <= 1'b0;
      MEAS_EN   <= 1'b0;
      RES_VALID <= 1'b0;
      RES_MODE  <= 16'd0;
      RES_ERRS  <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      err_cnt   <= err_cnt_n;
      MAIN_MODE <= main_n;
      SUB_MODE  <= sub_n;
      POR       <= por_n;
      MEAS_EN   <= meas_en_n;
      RES_VALID <= res_valid_n;
      RES_MODE  <= res_mode_n;
      RES_ERRS  <= res_errs_n;
      BUSY      <= busy_n;
      DONE      <= done_n;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned, which would otherwise infer a latch.
    state_n     = state;
    cnt_n       = cnt;
    err_cnt_n   = err_cnt;
    main_n      = MAIN_MODE;
    sub_n       = SUB_MODE;
    por_n       = 1'b0;
    meas_en_n   = 1'b0;
    res_valid_n = 1'b0;
    res_mode_n  = RES_MODE;
    res_errs_n  = RES_ERRS;
    done_n      = DONE;

    unique case (state)
      S_IDLE, S_DONE: begin
        if (START && !ABORT) begin
          state_n = S_POR;
          main_n  = FIRST8;
          sub_n   = 8'd0;
          cnt_n   = POR_LOAD;
          done_n  = 1'b0;
          por_n   = 1'b1;
        end
      end
      S_POR: begin
        por_n = 1'b1;
        if (cnt == '0) begin
          por_n   = 1'b0;
          cnt_n   = SETTLE_LOAD;
          state_n = S_SETTLE;
        end else begin
          cnt_n = cnt - CYC_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt == '0) begin
          cnt_n     = MEAS_LOAD;
          err_cnt_n = '0;
          meas_en_n = 1'b1;
          state_n   = S_MEAS;
        end else begin
          cnt_n = cnt - CYC_W'(1);
        end
      end
      S_MEAS: begin
        meas_en_n = 1'b1;
        // Saturate rather than wrap so a very noisy mode still reads as bad.
        if (ERR && (err_cnt != '1)) err_cnt_n = err_cnt + CNT_W'(1);
        if (cnt == '0) begin
          meas_en_n   = 1'b0;
          res_mode_n  = {MAIN_MODE, SUB_MODE};
          res_errs_n  = err_cnt_n;
          res_valid_n = 1'b1;
          state_n     = S_REPORT;
        end else begin
          cnt_n = cnt - CYC_W'(1);
        end
      end
      S_REPORT: begin
        res_valid_n = 1'b1;
        if (RES_READY) begin
          res_valid_n = 1'b0;
          if (SUB_MODE < SUB8) begin
            sub_n   = SUB_MODE + 8'd1;
            cnt_n   = POR_LOAD;
            por_n   = 1'b1;
            state_n = S_POR;
          end else if (MAIN_MODE < LAST8) begin
            main_n  = MAIN_MODE + 8'd1;
            sub_n   = 8'd0;
            cnt_n   = POR_LOAD;
            por_n   = 1'b1;
            state_n = S_POR;
          end else begin
            done_n  = 1'b1;
            state_n = S_DONE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Abort overrides whatever the active state decided; the result in flight is dropped.
    if (ABORT && (state != S_IDLE) && (state != S_DONE)) begin
      state_n     = S_IDLE;
      por_n       = 1'b0;
      meas_en_n   = 1'b0;
      res_valid_n = 1'b0;
      done_n      = 1'b0;
      main_n      = FIRST8;
      sub_n       = 8'd0;
    end

    busy_n = (state_n != S_IDLE) && (state_n != S_DONE);
  end

endmodule

// File: tb/tb_stim_mode_sequencer.sv
// Directed bench for stim_mode_sequencer: short sweep, error counting, saturation,
// backpressure, abort and asynchronous reset.
module tb_stim_mode_sequencer;

  logic        CLK = 1'b0;
  logic        RST, START, ABORT, ERR, RES_READY;
  logic [7:0]  MAIN_MODE, SUB_MODE;
  logic        POR, MEAS_EN, RES_VALID, BUSY, DONE;
  logic [15:0] RES_MODE, RES_ERRS;

  logic [7:0]  s_main, s_sub;
  logic        s_por, s_meas, s_valid, s_busy, s_done;
  logic [15:0] s_mode;
  logic [1:0]  s_errs;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  stim_mode_sequencer #(
    .MODE_FIRST(9), .MODE_LAST(10), .SUB_LAST(1),
    .POR_CYC(2), .SETTLE_CYC(3), .MEAS_CYC(8), .CNT_W(16)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .ERR(ERR),
    .RES_READY(RES_READY), .MAIN_MODE(MAIN_MODE), .SUB_MODE(SUB_MODE),
    .POR(POR), .MEAS_EN(MEAS_EN), .RES_VALID(RES_VALID), .RES_MODE(RES_MODE),
    .RES_ERRS(RES_ERRS), .BUSY(BUSY), .DONE(DONE)
  );

  // Same stimulus into a 2-bit counter instance to observe saturation.
  stim_mode_sequencer #(
    .MODE_FIRST(9), .MODE_LAST(10), .SUB_LAST(1),
    .POR_CYC(2), .SETTLE_CYC(3), .MEAS_CYC(8), .CNT_W(2)
  ) dut_sat (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .ERR(ERR),
    .RES_READY(RES_READY), .MAIN_MODE(s_main), .SUB_MODE(s_sub),
    .POR(s_por), .MEAS_EN(s_meas), .RES_VALID(s_valid), .RES_MODE(s_mode),
    .RES_ERRS(s_errs), .BUSY(s_busy), .DONE(s_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge where the step's first POR cycle is visible; returns at the
  // negedge after the handshake.
  task automatic run_step(input logic [15:0] exp_mode, input int n_meas, input int n_settle,
                          input logic [15:0] exp_errs, input logic [1:0] exp_sat,
                          input int bp, input bit last);
    int por_c = 0, meas_c = 0, lat = 0, em = 0, es = 0;
    bit got = 1'b0, stable = 1'b1;
    logic [15:0] m0, e0;
    RES_READY = (bp == 0);
    for (int i = 0; i < 200; i++) begin
      if (RES_VALID) begin got = 1'b1; break; end
      if (BUSY) lat++;
      if (POR) por_c++;
      if (MEAS_EN) meas_c++;
      ERR = 1'b0;
      if (MEAS_EN && em < n_meas) begin ERR = 1'b1; em++; end
      else if (BUSY && !POR && !MEAS_EN && es < n_settle) begin ERR = 1'b1; es++; end
      @(negedge CLK);
    end
    ERR = 1'b0;
    check("res_valid_seen", 32'(got), 32'd1);
    check("res_mode", 32'(RES_MODE), 32'(exp_mode));
    check("res_errs", 32'(RES_ERRS), 32'(exp_errs));
    check("res_errs_sat", 32'(s_errs), 32'(exp_sat));
    check("por_width", por_c, 2);
    check("meas_width", meas_c, 8);
    check("latency", lat, 13);
    m0 = RES_MODE;
    e0 = RES_ERRS;
    for (int j = 1; j < bp; j++) begin
      @(negedge CLK);
      if (!RES_VALID || RES_MODE !== m0 || RES_ERRS !== e0) stable = 1'b0;
    end
    if (bp > 0) check("bp_stable", 32'(stable), 32'd1);
    RES_READY = 1'b1;
    @(negedge CLK);
    check("valid_drop", 32'(RES_VALID), 32'd0);
    if (last) begin
      check("done_set", 32'(DONE), 32'd1);
      check("busy_clear", 32'(BUSY), 32'd0);
    end else begin
      check("next_por", 32'(POR), 32'd1);
    end
  endtask

  task automatic pulse_start();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  initial begin
    bit found, quiet;
    RST = 1'b1; START = 1'b0; ABORT = 1'b0; ERR = 1'b0; RES_READY = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_main", 32'(MAIN_MODE), 32'h09);
    check("rst_sub", 32'(SUB_MODE), 32'h00);
    check("rst_flags", {27'd0, POR, MEAS_EN, RES_VALID, BUSY, DONE}, 32'd0);
    check("rst_res", {RES_MODE, RES_ERRS}, 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Basic sweep with error injection, saturation and backpressure.
    pulse_start();
    check("start_por", 32'(POR), 32'd1);
    check("start_busy", 32'(BUSY), 32'd1);
    run_step(16'h0900, 5, 3, 16'd5, 2'd3, 0, 1'b0);
    run_step(16'h0901, 8, 0, 16'd8, 2'd3, 10, 1'b0);
    run_step(16'h0A00, 0, 0, 16'd0, 2'd0, 0, 1'b0);
    run_step(16'h0A01, 0, 0, 16'd0, 2'd0, 0, 1'b1);
    repeat (3) @(negedge CLK);
    check("done_sticky", 32'(DONE), 32'd1);
    check("done_modes", {16'd0, MAIN_MODE, SUB_MODE}, 32'h0A01);

    // Restart from DONE, then abort during the measurement window of 0x0901.
    pulse_start();
    check("restart_done_clr", 32'(DONE), 32'd0);
    check("restart_modes", {16'd0, MAIN_MODE, SUB_MODE}, 32'h0900);
    run_step(16'h0900, 0, 0, 16'd0, 2'd0, 0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (MEAS_EN) begin found = 1'b1; break; end
      @(negedge CLK);
    end
    check("abort_reach_meas", 32'(found), 32'd1);
    repeat (2) @(negedge CLK);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_meas", 32'(MEAS_EN), 32'd0);
    check("abort_done", 32'(DONE), 32'd0);
    check("abort_modes", {16'd0, MAIN_MODE, SUB_MODE}, 32'h0900);
    quiet = 1'b1;
    repeat (12) begin
      if (RES_VALID || BUSY) quiet = 1'b0;
      @(negedge CLK);
    end
    check("abort_quiet", 32'(quiet), 32'd1);

    // Restart after abort, then reset asynchronously mid-POR of the next step.
    pulse_start();
    check("abort_restart_por", 32'(POR), 32'd1);
    run_step(16'h0900, 0, 0, 16'd0, 2'd0, 0, 1'b0);
    RST = 1'b1;
    START = 1'b1;
    #1;
    check("rst_async_por", 32'(POR), 32'd0);
    check("rst_async_busy", 32'(BUSY), 32'd0);
    check("rst_async_res", {RES_MODE, RES_ERRS}, 32'd0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    START = 1'b0;
    @(negedge CLK);
    check("rst_start_ignored", {30'd0, POR, BUSY}, 32'd0);

    // START and ABORT together while idle: abort wins.
    START = 1'b1;
    ABORT = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    ABORT = 1'b0;
    check("start_abort_busy", 32'(BUSY), 32'd0);
    check("start_abort_por", 32'(POR), 32'd0);
    pulse_start();
    check("final_start_por", 32'(POR), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
